ula_multiciclo: RTL and testbench
=================================

Name: ula_multiciclo

Overview:
- Parametrised, multi-cycle successor of the processor's combinational add/sub ULA. Operand width is configurable and the op set is extended.
- Iterative shifts and an optional iterative multiply run over several cycles under a start/busy/done handshake.
- Zero, carry, overflow and negative flags are registered. The datapath controller uses `zero` for branch-taken decisions, as before.
- Sits between the register-file read ports and the writeback mux. The control FSM holds the operands stable while `busy` is high.

Parameters:
- WIDTH, 8, operand/result width; must be a power of two, 4..32.
- SHW (localparam), $clog2(WIDTH), shift-amount width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only while `busy` is low
- ctrl_ula  in  3  opcode; sampled with `start`
- num2  in  WIDTH  left operand (minuend / shifted value)
- num1  in  WIDTH  right operand (subtrahend / shift amount source)
- busy  out  1  high while a multi-cycle op is in progress
- done  out  1  one-cycle pulse: `resultado` and flags are valid
- resultado  out  WIDTH  registered result, held until the next completion
- zero  out  1  `resultado` == 0 (every op)
- carry  out  1  see arithmetic rules
- overflow  out  1  signed overflow
- negative  out  1  `resultado`[WIDTH-1]

Behaviour:
- Reset: the asynchronous, active-low `resetn` drives state to IDLE. All outputs go to 0, including `busy`, `done`, `resultado` and every flag.
- Opcodes (`ctrl_ula`):
  - 000 ADD: num2+num1
  - 001 SUB: num2-num1
  - 010 AND
  - 011 OR
  - 100 SLT: 1 if $signed(num2) < $signed(num1), else 0
  - 101 SLL: num2 << num1[SHW-1:0]
  - 110 SRL: logical num2 >> num1[SHW-1:0]
  - 111 MUL: low WIDTH bits of num2*num1 (see Optional Feature)
- Arithmetic and flag rules:
  - ADD: carry = carry-out of the WIDTH-bit sum.
  - SUB: carry = 1 when num2 >= num1 unsigned (no borrow).
  - Overflow is computed for ADD and SUB only, using the standard sign rule.
  - carry and overflow are 0 for all other ops.
  - Results wrap modulo 2^WIDTH.
- States:
  - IDLE to IDLE: on `start` with a single-cycle op (000–100), with SLL/SRL when the shift amount is 0, or with 111 when ULA_MUL_EN is undefined.
  - IDLE to SHIFT: on `start` with SLL/SRL and a nonzero shift amount.
  - IDLE to MUL: on `start` with 111 when ULA_MUL_EN is defined.
  - SHIFT to IDLE: when the remaining count reaches 0.
  - MUL to IDLE: after WIDTH iterations.
- Latency: `start` is sampled at edge k; `done` is high for the cycle following edge k+L.
  - Single-cycle ops: L = 1.
  - Shifts: L = max(1, shamt), one bit shifted per cycle.
  - MUL: L = WIDTH, shift-add of one multiplier bit per cycle.
- `busy`:
  - Rises after edge k for multi-cycle ops.
  - Falls on the same edge at which `done` rises.
  - Never asserted for single-cycle ops.
- Operand capture: operands and opcode are latched at `start`. Input changes during `busy` have no effect.
- `start` while `busy` is high: ignored; the in-flight op completes unaffected.
- `start` in the same cycle that `done` is high: accepted normally (back-to-back, one per cycle for single-cycle ops).
- `resultado` and flags: update only at completion and hold their values otherwise.
- `resetn` low mid-operation: aborts immediately. No `done` pulse is produced, and outputs return to reset values.

Optional Feature:
- Macro: ULA_MUL_EN.
- Defined: opcode 111 runs the iterative multiplier, with latency WIDTH. Flags: zero and negative from the result; carry = 1 if the discarded upper WIDTH bits are nonzero; overflow = 0.
- Undefined: the multiplier logic is absent. Opcode 111 completes in 1 cycle with `resultado` = 0, zero = 1 and all other flags 0.

Decomposition:
- Package `ula_pkg`:
  - op enum: ULA_ADD, ULA_SUB, ULA_AND, ULA_OR, ULA_SLT, ULA_SLL, ULA_SRL, ULA_MUL
  - state enum: ST_IDLE, ST_SHIFT, ST_MUL
- Sub-module `ula_mul_seq`: iterative shift-add multiplier with its own start/done. Instantiated only under ULA_MUL_EN.

Test Plan:
- ADD (WIDTH=8): num2=200, num1=100, start → `done` 1 cycle later; `resultado`=0x2C, carry=1, overflow=0, zero=0, `busy` never high.
- SUB: 5-5 → `resultado`=0, zero=1, carry=1. Then 3-5 → `resultado`=0xFE, carry=0, negative=1. Issue both back-to-back: two consecutive `done` pulses.
- SLT: num2=0xFE, num1=0x01 → `resultado`=1. Swapped operands → 0. ADD 0x7F+0x01 → `resultado`=0x80, overflow=1.
- SLL: num2=0x01, num1=7 → `busy` high 7 cycles, `done` at L=7, `resultado`=0x80. SRL by 0 → `done` at L=1, `resultado`=num2.
- MUL (ULA_MUL_EN defined): 13×11 → `done` at L=8, `resultado`=0x8F, carry=0. A second `start` at cycle 3 is ignored. 16×16 → `resultado`=0x00, zero=1, carry=1.
- Reset: drive `resetn` low mid-MUL at cycle 4 → all outputs 0 immediately, no `done` pulse. A new ADD after release works. With ULA_MUL_EN undefined: opcode 111 → `done` at L=1, `resultado`=0, zero=1.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared opcode and control-state types for the multi-cycle ULA.
package ula_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        ULA_ADD = 3'b000,
        ULA_SUB = 3'b001,
        ULA_AND = 3'b010,
        ULA_OR  = 3'b011,
        ULA_SLT = 3'b100,
        ULA_SLL = 3'b101,
        ULA_SRL = 3'b110,
        ULA_MUL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_MUL
    } state_t;

endpackage

// File: rtl/ula_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// done_o/prod_o are combinational in the final iteration so the caller can register them on that edge.
module ula_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   prod_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               last;

    always_comb begin
        acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
        last     = busy_q && (cnt_q == CW'(1));
        done_o   = last;
        prod_o   = acc_nxt;

        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;

        if (start_i) begin
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ULA: single-cycle ALU ops, bit-serial shifts, optional iterative MUL (ULA_MUL_EN).
// Result and flags are registered and only change on a done pulse; start is ignored while busy.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       ctrl_ula,
    input  logic [WIDTH-1:0] num2,
    input  logic [WIDTH-1:0] num1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resultado,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, neg_q, neg_d;

    op_t              op_in;
    logic             accept;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] shifted, fin_res;
    logic             fin, fin_c, fin_v;

    assign op_in  = op_t'(ctrl_ula);
    assign accept = (state_q == ST_IDLE) && start;

`ifdef ULA_MUL_EN
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .resetn  (resetn),
        .start_i (accept && (op_in == ULA_MUL)),
        .a_i     (num2),
        .b_i     (num1),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
        fin     = 1'b0;
        fin_res = '0;
        fin_c   = 1'b0;
        fin_v   = 1'b0;

        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        shifted = (op_q == ULA_SLL) ? (a_q << 1) : (a_q >> 1);

        // Single-cycle ops complete one edge after capture from the latched operands.
        if (pend_q) begin
            fin = 1'b1;
            case (op_q)
                ULA_ADD: begin
                    fin_res = sum[MSB:0];
                    fin_c   = sum[WIDTH];
                    fin_v   = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
                end
                ULA_SUB: begin
                    fin_res = diff[MSB:0];
                    fin_c   = ~diff[WIDTH];
                    fin_v   = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
                end
                ULA_AND: fin_res = a_q & b_q;
                ULA_OR:  fin_res = a_q | b_q;
                ULA_SLT: fin_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                ULA_SLL: fin_res = a_q << b_q[SHW-1:0];
                ULA_SRL: fin_res = a_q >> b_q[SHW-1:0];
                default: fin_res = '0;
            endcase
        end

        if (state_q == ST_SHIFT) begin
            a_d   = shifted;
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                fin     = 1'b1;
                fin_res = shifted;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        end

`ifdef ULA_MUL_EN
        if ((state_q == ST_MUL) && mul_done) begin
            fin     = 1'b1;
            fin_res = mul_prod[MSB:0];
            fin_c   = |mul_prod[2*WIDTH-1:WIDTH];
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end
`endif

        if (fin) begin
            done_d  = 1'b1;
            res_d   = fin_res;
            zero_d  = (fin_res == '0);
            carry_d = fin_c;
            ovf_d   = fin_v;
            neg_d   = fin_res[MSB];
        end

        if (accept) begin
            op_d = op_in;
            a_d  = num2;
            b_d  = num1;
            if (((op_in == ULA_SLL) || (op_in == ULA_SRL)) && (num1[SHW-1:0] != '0)) begin
                state_d = ST_SHIFT;
                cnt_d   = num1[SHW-1:0];
                busy_d  = 1'b1;
            end
`ifdef ULA_MUL_EN
            else if (op_in == ULA_MUL) begin
                state_d = ST_MUL;
                busy_d  = 1'b1;
            end
`endif
            else begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= ULA_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign resultado = res_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign negative  = neg_q;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed-vector bench for ula_multiciclo (WIDTH=8); MUL expectations follow ULA_MUL_EN.
module tb_ula_multiciclo;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [2:0] ctrl_ula;
    logic [7:0] num2, num1;
    logic       busy, done, zero, carry, overflow, negative;
    logic [7:0] resultado;

    int total = 0;
    int bad   = 0;
    int lat, nb, ndone;

    ula_multiciclo #(.WIDTH(8)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .ctrl_ula  (ctrl_ula),
        .num2      (num2),
        .num1      (num1),
        .busy      (busy),
        .done      (done),
        .resultado (resultado),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic outs(input string t, input logic [7:0] r,
                        input logic z, input logic c, input logic v, input logic n);
        check({t, ".res"}, resultado, r);
        check({t, ".zero"}, zero, z);
        check({t, ".carry"}, carry, c);
        check({t, ".ovf"}, overflow, v);
        check({t, ".neg"}, negative, n);
    endtask

    // Issues one op and waits (bounded) for done; lat is in cycles after the sampling edge.
    // Inputs are scrambled while the op runs; a stray start is driven at cycle 'poke'.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int poke, output int l, output int nbusy);
        @(negedge clock);
        start = 1'b1; ctrl_ula = op; num2 = a; num1 = b;
        @(negedge clock);
        start = 1'b0; ctrl_ula = 3'b000; num2 = 8'hAA; num1 = 8'h55;
        l = -1;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            start = (i == poke);
            if (busy) nbusy++;
            if (done) begin
                l = i;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; ctrl_ula = 3'b000; num2 = 8'h00; num1 = 8'h00;
        repeat (2) @(negedge clock);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        outs("rst", 8'h00, 0, 0, 0, 0);
        resetn = 1'b1;

        run_op(3'b000, 8'd200, 8'd100, -1, lat, nb);
        check("add.lat", lat, 1);
        check("add.busy_cycles", nb, 0);
        outs("add", 8'h2C, 0, 1, 0, 0);
        @(negedge clock);
        check("add.single_pulse", done, 0);

        // Back-to-back SUBs, one per cycle
        start = 1'b1; ctrl_ula = 3'b001; num2 = 8'd5; num1 = 8'd5;
        @(negedge clock);
        check("sub_b2b.no_early_done", done, 0);
        ctrl_ula = 3'b001; num2 = 8'd3; num1 = 8'd5;
        @(negedge clock);
        start = 1'b0;
        check("sub1.done", done, 1);
        outs("sub1", 8'h00, 1, 1, 0, 0);
        @(negedge clock);
        check("sub2.done", done, 1);
        outs("sub2", 8'hFE, 0, 0, 0, 1);

        run_op(3'b100, 8'hFE, 8'h01, -1, lat, nb);
        check("slt.lat", lat, 1);
        outs("slt", 8'h01, 0, 0, 0, 0);
        run_op(3'b100, 8'h01, 8'hFE, -1, lat, nb);
        outs("slt_sw", 8'h00, 1, 0, 0, 0);
        run_op(3'b000, 8'h7F, 8'h01, -1, lat, nb);
        outs("add_ovf", 8'h80, 0, 0, 1, 1);
        run_op(3'b010, 8'hF0, 8'h3C, -1, lat, nb);
        outs("and", 8'h30, 0, 0, 0, 0);
        run_op(3'b011, 8'h0F, 8'h30, -1, lat, nb);
        outs("or", 8'h3F, 0, 0, 0, 0);

        run_op(3'b101, 8'h01, 8'd7, -1, lat, nb);
        check("sll7.lat", lat, 7);
        check("sll7.busy_cycles", nb, 7);
        check("sll7.busy_low_at_done", busy, 0);
        outs("sll7", 8'h80, 0, 0, 0, 1);
        run_op(3'b110, 8'hB5, 8'd8, -1, lat, nb);
        check("srl0.lat", lat, 1);
        check("srl0.busy_cycles", nb, 0);
        outs("srl0", 8'hB5, 0, 0, 0, 1);
        run_op(3'b110, 8'h80, 8'd3, -1, lat, nb);
        check("srl3.lat", lat, 3);
        outs("srl3", 8'h10, 0, 0, 0, 0);

        // Reset in the middle of a multi-cycle op
        @(negedge clock);
`ifdef ULA_MUL_EN
        ctrl_ula = 3'b111;
`else
        ctrl_ula = 3'b101;
`endif
        start = 1'b1; num2 = 8'd13; num1 = 8'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check("rstmid.busy_before", busy, 1);
        resetn = 1'b0;
        #1;
        check("rstmid.busy", busy, 0);
        check("rstmid.done", done, 0);
        outs("rstmid", 8'h00, 0, 0, 0, 0);
        ndone = 0;
        repeat (3) @(negedge clock) if (done) ndone++;
        resetn = 1'b1;
        repeat (12) @(negedge clock) if (done) ndone++;
        check("rstmid.no_done", ndone, 0);
        run_op(3'b000, 8'd1, 8'd2, -1, lat, nb);
        check("post_rst_add.lat", lat, 1);
        outs("post_rst_add", 8'h03, 0, 0, 0, 0);

`ifdef ULA_MUL_EN
        run_op(3'b111, 8'd13, 8'd11, 3, lat, nb);
        check("mul.lat", lat, 8);
        check("mul.busy_cycles", nb, 8);
        outs("mul", 8'h8F, 0, 0, 0, 1);
        @(negedge clock);
        check("mul.no_extra_done", done, 0);
        run_op(3'b111, 8'd16, 8'd16, -1, lat, nb);
        check("mul16.lat", lat, 8);
        outs("mul16", 8'h00, 1, 1, 0, 0);
`else
        run_op(3'b111, 8'd13, 8'd11, -1, lat, nb);
        check("mul_off.lat", lat, 1);
        check("mul_off.busy_cycles", nb, 0);
        outs("mul_off", 8'h00, 1, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
